pwm_bank: RTL and testbench

Multi-channel, register-mapped PWM generator for the Bus Pirate FPGA. It replaces the single free-running on/off PWM with `CHANNELS` independent counters, each with:
- double-buffered on/off times
- continuous or one-shot mode
- output inversion
- a sticky completion flag that drives an interrupt line.

It sits on the synchronized memory-controller register bus beside the FIFOs. Its outputs feed the IO pin muxes and the irq pins.

---
 rtl/pwm_bank.sv | 246 ++++++++++++++++++++++++
 tb/tb_pwm_bank.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_bank.sv
// pwm_bank
//   Multi-channel, register-mapped PWM generator. Each channel has its own
//   phase counter, double-buffered on/off times, continuous or one-shot
//   mode, output inversion and a sticky completion flag feeding irq.
//
// Ports
//   clock      system clock
//   reset      asynchronous, active-high reset
//   wr_strobe  single-cycle synchronized write pulse
//   rd_strobe  single-cycle synchronized read pulse
//   addr       register address
//   wdata      write data
//   rdata      registered read data, held until the next read
//   pwm_out    registered PWM outputs, one per channel
//   irq        registered OR of (done & irq_en) over all channels
//
// Register map (channel c at BASE+3c)
//   +0 ON, +1 OFF, +2 CTRL {busy(ro), irq_en, invert, oneshot, enable}
//   BASE+3*CHANNELS: STATUS, bit c = done[c], write-1-to-clear
module pwm_bank #(
    parameter int unsigned          CHANNELS  = 4,
    parameter int unsigned          CNT_WIDTH = 16,
    parameter int unsigned          ADD_WIDTH = 6,
    parameter logic [ADD_WIDTH-1:0] BASE      = 6'h10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wr_strobe,
    input  logic                 rd_strobe,
    input  logic [ADD_WIDTH-1:0] addr,
    input  logic [CNT_WIDTH-1:0] wdata,
    output logic [CNT_WIDTH-1:0] rdata,
    output logic [CHANNELS-1:0]  pwm_out,
    output logic                 irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } state_t;

    // Programmer-visible registers
    logic [CNT_WIDTH-1:0] on_q   [CHANNELS];
    logic [CNT_WIDTH-1:0] on_d   [CHANNELS];
    logic [CNT_WIDTH-1:0] off_q  [CHANNELS];
    logic [CNT_WIDTH-1:0] off_d  [CHANNELS];
    logic [CHANNELS-1:0]  en_q, en_d;
    logic [CHANNELS-1:0]  os_q, os_d;
    logic [CHANNELS-1:0]  inv_q, inv_d;
    logic [CHANNELS-1:0]  ie_q, ie_d;
    logic [CHANNELS-1:0]  done_q, done_d;

    // Per-channel engine state
    state_t               state_q [CHANNELS];
    state_t               state_d [CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_q   [CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_d   [CHANNELS];
    logic [CNT_WIDTH-1:0] ons_q   [CHANNELS];
    logic [CNT_WIDTH-1:0] ons_d   [CHANNELS];
    logic [CNT_WIDTH-1:0] offs_q  [CHANNELS];
    logic [CNT_WIDTH-1:0] offs_d  [CHANNELS];

    // Outputs
    logic [CNT_WIDTH-1:0] rdata_q, rdata_d;
    logic [CHANNELS-1:0]  pwm_q, pwm_d;
    logic                 irq_q, irq_d;

    logic [CHANNELS-1:0]  done_set;
    logic [CHANNELS-1:0]  done_clr;
    logic [CHANNELS-1:0]  period_end;

    function automatic logic [ADD_WIDTH-1:0] reg_addr(input int unsigned idx);
        return ADD_WIDTH'(32'(BASE) + idx);
    endfunction

    localparam int unsigned STATUS_IDX = 3 * CHANNELS;

    always_comb begin
        en_d       = en_q;
        os_d       = os_q;
        inv_d      = inv_q;
        ie_d       = ie_q;
        done_set   = '0;
        done_clr   = '0;
        period_end = '0;
        rdata_d    = rdata_q;
        pwm_d      = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            on_d[c]    = on_q[c];
            off_d[c]   = off_q[c];
            state_d[c] = state_q[c];
            cnt_d[c]   = cnt_q[c];
            ons_d[c]   = ons_q[c];
            offs_d[c]  = offs_q[c];
        end

        // Bus writes; unmapped addresses fall through untouched
        if (wr_strobe) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (addr == reg_addr(3 * c)) begin
                    on_d[c] = wdata;
                end
                if (addr == reg_addr(3 * c + 1)) begin
                    off_d[c] = wdata;
                end
                if (addr == reg_addr(3 * c + 2)) begin
                    en_d[c]  = wdata[0];
                    os_d[c]  = wdata[1];
                    inv_d[c] = wdata[2];
                    ie_d[c]  = wdata[3];
                end
            end
            if (addr == reg_addr(STATUS_IDX)) begin
                done_clr = wdata[CHANNELS-1:0];
            end
        end

        // Bus reads; a simultaneous write suppresses the read so rdata holds
        if (rd_strobe && !wr_strobe) begin
            rdata_d = '0;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (addr == reg_addr(3 * c)) begin
                    rdata_d = on_q[c];
                end
                if (addr == reg_addr(3 * c + 1)) begin
                    rdata_d = off_q[c];
                end
                if (addr == reg_addr(3 * c + 2)) begin
                    rdata_d = CNT_WIDTH'({(state_q[c] != S_IDLE), ie_q[c],
                                          inv_q[c], os_q[c], en_q[c]});
                end
            end
            if (addr == reg_addr(STATUS_IDX)) begin
                rdata_d = CNT_WIDTH'(done_q);
            end
        end

        // Channel engines act on the registered CTRL, so a CTRL write is
        // seen one edge after it lands.
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (!en_q[c]) begin
                state_d[c] = S_IDLE;
                cnt_d[c]   = '0;
            end else begin
                unique case (state_q[c])
                    S_IDLE: begin
                        ons_d[c]   = on_q[c];
                        offs_d[c]  = off_q[c];
                        cnt_d[c]   = '0;
                        state_d[c] = (on_q[c] == '0) ? S_OFF : S_ON;
                    end
                    S_ON: begin
                        if (cnt_q[c] == ons_q[c] - CNT_WIDTH'(1)) begin
                            cnt_d[c] = '0;
                            if (offs_q[c] == '0) begin
                                period_end[c] = 1'b1;
                            end else begin
                                state_d[c] = S_OFF;
                            end
                        end else begin
                            cnt_d[c] = cnt_q[c] + CNT_WIDTH'(1);
                        end
                    end
                    S_OFF: begin
                        // off_s==0 only reaches here with on_s==0: one
                        // inactive cycle per period.
                        if (offs_q[c] == '0 ||
                            cnt_q[c] == offs_q[c] - CNT_WIDTH'(1)) begin
                            period_end[c] = 1'b1;
                        end else begin
                            cnt_d[c] = cnt_q[c] + CNT_WIDTH'(1);
                        end
                    end
                    default: begin
                        state_d[c] = S_IDLE;
                        cnt_d[c]   = '0;
                    end
                endcase

                if (period_end[c]) begin
                    cnt_d[c] = '0;
                    if (os_q[c]) begin
                        // Completion overrides any CTRL write landing now
                        state_d[c]  = S_IDLE;
                        en_d[c]     = 1'b0;
                        done_set[c] = 1'b1;
                    end else begin
                        ons_d[c]   = on_q[c];
                        offs_d[c]  = off_q[c];
                        state_d[c] = (on_q[c] == '0) ? S_OFF : S_ON;
                    end
                end
            end

            pwm_d[c] = inv_d[c] ^ (state_d[c] == S_ON);
        end

        // A completion on the same edge as a W1C clear keeps the flag set
        done_d = (done_q & ~done_clr) | done_set;
        irq_d  = |(done_q & ie_q);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            en_q    <= '0;
            os_q    <= '0;
            inv_q   <= '0;
            ie_q    <= '0;
            done_q  <= '0;
            rdata_q <= '0;
            pwm_q   <= '0;
            irq_q   <= 1'b0;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                on_q[c]    <= '0;
                off_q[c]   <= '0;
                state_q[c] <= S_IDLE;
                cnt_q[c]   <= '0;
                ons_q[c]   <= '0;
                offs_q[c]  <= '0;
            end
        end else begin
            en_q    <= en_d;
            os_q    <= os_d;
            inv_q   <= inv_d;
            ie_q    <= ie_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            pwm_q   <= pwm_d;
            irq_q   <= irq_d;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                on_q[c]    <= on_d[c];
                off_q[c]   <= off_d[c];
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
                ons_q[c]   <= ons_d[c];
                offs_q[c]  <= offs_d[c];
            end
        end
    end

    assign rdata   = rdata_q;
    assign pwm_out = pwm_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_pwm_bank.sv
module tb_pwm_bank;

  localparam int SEL_RDATA = 0;
  localparam int SEL_PWM   = 1;
  localparam int SEL_IRQ   = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        wr_strobe;
  logic        rd_strobe;
  logic [5:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic [3:0]  pwm_out;
  logic        irq;

  pwm_bank #(
    .CHANNELS (4),
    .CNT_WIDTH(16),
    .ADD_WIDTH(6),
    .BASE     (6'h10)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .wr_strobe(wr_strobe),
    .rd_strobe(rd_strobe),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .pwm_out  (pwm_out),
    .irq      (irq)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    int          sel;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_err    = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin : monitor
    logic [15:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        case (sb[i].sel)
          SEL_RDATA: act = rdata;
          SEL_PWM:   act = {12'h000, pwm_out};
          default:   act = {15'h0000, irq};
        endcase
        n_checks++;
        if (sb[i].cyc != cyc || act !== sb[i].exp) begin
          n_err++;
          $display("FAIL %s cyc=%0d due=%0d got=%h want=%h",
                   sb[i].name, cyc, sb[i].cyc, act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_at(input int c, input int sel, input logic [15:0] e,
                           input string nm);
    exp_t x;
    x.cyc  = c;
    x.sel  = sel;
    x.exp  = e;
    x.name = nm;
    sb.push_back(x);
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] d);
    addr      = a;
    wdata     = d;
    wr_strobe = 1'b1;
    tick();
    wr_strobe = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, input logic [15:0] e, input string nm);
    addr      = a;
    rd_strobe = 1'b1;
    expect_at(cyc + 1, SEL_RDATA, e, nm);
    tick();
    rd_strobe = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int k;
    reset     = 1'b1;
    wr_strobe = 1'b0;
    rd_strobe = 1'b0;
    addr      = '0;
    wdata     = '0;

    tick();
    expect_at(cyc, SEL_RDATA, 16'h0000, "rst_rdata");
    expect_at(cyc, SEL_PWM,   16'h0000, "rst_pwm");
    expect_at(cyc, SEL_IRQ,   16'h0000, "rst_irq");
    tick();
    reset = 1'b0;
    tick();
    rd(6'h10, 16'h0000, "rst_on0");
    rd(6'h12, 16'h0000, "rst_ctrl0");
    rd(6'h1C, 16'h0000, "rst_status");

    wr(6'h10, 16'd3);
    wr(6'h11, 16'd2);
    wr(6'h12, 16'h0001);
    k = cyc;
    for (int i = 0; i < 20; i++)
      expect_at(k + 1 + i, SEL_PWM, (i % 5 < 3) ? 16'h0001 : 16'h0000, "cont");
    repeat (20) tick();
    rd(6'h12, 16'h0011, "cont_busy");
    wr(6'h12, 16'h0000);
    tick();
    tick();

    wr(6'h13, 16'd2);
    wr(6'h14, 16'd1);
    wr(6'h15, 16'h000B);
    k = cyc;
    for (int i = 1; i <= 8; i++)
      expect_at(k + i, SEL_PWM, (i <= 2) ? 16'h0002 : 16'h0000, "oneshot");
    expect_at(k + 4, SEL_IRQ, 16'h0000, "os_irq_early");
    expect_at(k + 5, SEL_IRQ, 16'h0001, "os_irq");
    repeat (8) tick();
    rd(6'h1C, 16'h0002, "os_status");
    rd(6'h15, 16'h000A, "os_ctrl");
    wr(6'h1C, 16'h0002);
    expect_at(cyc + 1, SEL_IRQ, 16'h0000, "irq_clr");
    tick();
    n_checks++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL irq_clr_direct got=%b want=0", irq);
    end
    rd(6'h1C, 16'h0000, "status_clr");

    wr(6'h10, 16'd4);
    wr(6'h11, 16'd4);
    wr(6'h12, 16'h0001);
    k = cyc;
    for (int i = 1; i <= 19; i++)
      expect_at(k + i, SEL_PWM,
                (i <= 4 || i == 9 || i == 14 || i == 19) ? 16'h0001 : 16'h0000,
                "dbuf");
    tick();
    wr(6'h10, 16'd1);
    repeat (17) tick();
    wr(6'h12, 16'h0000);
    tick();
    tick();

    wr(6'h10, 16'd0);
    wr(6'h11, 16'd5);
    wr(6'h12, 16'h0001);
    k = cyc;
    for (int i = 0; i <= 12; i++)
      expect_at(k + i, SEL_PWM, 16'h0000, "on_zero");
    tick();
    rd(6'h12, 16'h0011, "on_zero_busy");
    repeat (10) tick();
    wr(6'h12, 16'h0000);

    wr(6'h10, 16'd4);
    wr(6'h11, 16'd0);
    wr(6'h12, 16'h0001);
    k = cyc;
    for (int i = 1; i <= 12; i++)
      expect_at(k + i, SEL_PWM, 16'h0001, "off_zero");
    repeat (12) tick();
    wr(6'h12, 16'h0000);
    tick();
    tick();

    wr(6'h16, 16'd0);
    wr(6'h17, 16'd0);
    wr(6'h18, 16'h0007);
    k = cyc;
    for (int i = 0; i <= 6; i++)
      expect_at(k + i, SEL_PWM, 16'h0004, "both_zero_inv");
    repeat (6) tick();
    rd(6'h1C, 16'h0004, "both_zero_done");
    rd(6'h18, 16'h0006, "both_zero_ctrl");
    wr(6'h18, 16'h0000);
    wr(6'h1C, 16'h0004);
    tick();

    wr(6'h18, 16'h0003);
    tick();
    wr(6'h1C, 16'h0004);
    rd(6'h1C, 16'h0004, "w1c_collide");

    addr      = 6'h19;
    wdata     = 16'h1234;
    wr_strobe = 1'b1;
    rd_strobe = 1'b1;
    expect_at(cyc + 1, SEL_RDATA, 16'h0004, "wrrd_hold");
    tick();
    wr_strobe = 1'b0;
    rd_strobe = 1'b0;
    rd(6'h19, 16'h1234, "wrrd_write");
    n_checks++;
    if (rdata !== 16'h1234) begin
      n_err++;
      $display("FAIL wrrd_write_direct got=%h want=1234", rdata);
    end
    wr(6'h1C, 16'h0004);

    wr(6'h11, 16'h55AA);
    rd(6'h11, 16'h55AA, "off0");
    rd(6'h1D, 16'h0000, "unmapped_rd");
    n_checks++;
    if (rdata !== 16'h0000) begin
      n_err++;
      $display("FAIL unmapped_rd_direct got=%h want=0000", rdata);
    end
    wr(6'h0F, 16'hFFFF);
    rd(6'h0F, 16'h0000, "unmapped_wr");

    rd(6'h11, 16'h55AA, "off0_pre_rst");
    wr(6'h10, 16'd100);
    wr(6'h12, 16'h0001);
    repeat (3) tick();
    expect_at(cyc, SEL_PWM, 16'h0001, "pre_rst_on");
    tick();
    reset = 1'b1;
    expect_at(cyc, SEL_PWM,   16'h0000, "async_rst_pwm");
    expect_at(cyc, SEL_RDATA, 16'h0000, "async_rst_rdata");
    expect_at(cyc, SEL_IRQ,   16'h0000, "async_rst_irq");
    #1;
    n_checks++;
    if (pwm_out !== 4'h0) begin
      n_err++;
      $display("FAIL async_rst_pwm_direct got=%h want=0", pwm_out);
    end
    n_checks++;
    if (rdata !== 16'h0000) begin
      n_err++;
      $display("FAIL async_rst_rdata_direct got=%h want=0000", rdata);
    end
    tick();
    reset = 1'b0;
    tick();
    rd(6'h10, 16'h0000, "post_rst_on0");
    rd(6'h11, 16'h0000, "post_rst_off0");
    rd(6'h12, 16'h0000, "post_rst_ctrl0");
    rd(6'h19, 16'h0000, "post_rst_on3");
    rd(6'h1C, 16'h0000, "post_rst_status");

    repeat (3) tick();
    while (sb.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL %s never checked due=%0d want=%h",
               sb[0].name, sb[0].cyc, sb[0].exp);
      void'(sb.pop_front());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
